jtag_resp_arbiter: RTL and testbench
====================================

Name: jtag_resp_arbiter

Overview:
- Runs in the CPU clock domain and sits between the JTAG debug-register core and several on-tile clients (debugger stub, JTAG UART, tile status agent).
- Shares the single 8-bit response register and its 3-bit address field among up to 7 requesters using round-robin arbitration.
- Holds each granted byte until the host acknowledges it.
- Decodes host writes (REG_UPDATE with data and address) and routes each byte to the addressed client.

Parameters:
NUM_REQ, 3, number of requesters; legal range 1..7; ids 0..NUM_REQ-1.
ACK_ID, 3'd7, host-write address that acknowledges the held response; also the idle code on reg_addr_d_o.
TO_W, 16, width of the ack-timeout counter; a timeout fires after 2^TO_W-1 cycles in HOLD.
TO_EN, 1, 1 enables the timeout; 0 means HOLD waits for ACK indefinitely.

Ports:
clk_i  in  1  CPU clock.
rst_i  in  1  reset; asynchronous, active-high.
reg_update_i  in  1  update strobe from the JTAG core; jtck domain, asynchronous to clk_i.
reg_q_i  in  8  host-written byte; stable while reg_update_i is high.
reg_addr_q_i  in  3  host-written address; stable while reg_update_i is high.
reg_d_o  out  8  response byte presented to the JTAG core.
reg_addr_d_o  out  3  source id of the held byte, or ACK_ID when nothing is held.
tx_req_i  in  NUM_REQ  per-client request to send a byte (level).
tx_data_i  in  8*NUM_REQ  per-client byte; client i uses bits [8i+7:8i].
tx_ack_o  out  NUM_REQ  one-cycle pulse: the client's byte was captured; the client may advance.
rx_valid_o  out  NUM_REQ  one-cycle pulse: a host byte is delivered to client i.
rx_data_o  out  8  byte accompanying rx_valid_o; held until the next delivery.
timeout_o  out  1  one-cycle pulse: the held byte was discarded by timeout.
busy_o  out  1  high while in HOLD.

Behaviour:
- Reset values: reg_d_o=0, reg_addr_d_o=ACK_ID, tx_ack_o=0, rx_valid_o=0, rx_data_o=0, timeout_o=0, busy_o=0, FSM=IDLE, RR pointer=0, timeout counter=0, sync flops=0.
- CDC: reg_update_i passes through a 2-flop synchronizer, then a third flop for rising-edge detection (upd_pulse).
  - reg_q_i and reg_addr_q_i are sampled on the upd_pulse cycle; the JTAG core holds them stable from the strobe onward.
  - Falling edges are ignored.
- Host-write decode, in the cycle after upd_pulse (3 clk_i edges after the reg_update_i rise is first captured):
  - addr < NUM_REQ: rx_valid_o[addr]=1 for 1 cycle; rx_data_o = the sampled byte.
  - addr == ACK_ID: ack event.
  - Any other addr: ignored, no outputs change.
  - There is no backpressure on the rx path; clients must accept every pulse.
- FSM, two states:
  - IDLE:
    - If any tx_req_i is high, pick the winner by round-robin: search starts at the RR pointer, with ids wrapping modulo NUM_REQ.
    - Same cycle: reg_d_o <= tx_data_i[winner], reg_addr_d_o <= winner, tx_ack_o[winner]=1 for 1 cycle, pointer <= (winner+1) mod NUM_REQ, counter <= 0, go to HOLD.
    - Grant latency is 1 cycle from the request being visible in IDLE.
  - HOLD:
    - busy_o=1. reg_d_o and reg_addr_d_o are frozen; tx_req_i is ignored.
    - Ack event: reg_addr_d_o <= ACK_ID, go to IDLE. reg_d_o keeps its last value.
    - TO_EN=1 and counter reaches all-ones without an ack: timeout_o=1 for 1 cycle, reg_addr_d_o <= ACK_ID, go to IDLE.
    - Otherwise the counter increments and saturates.
- Boundary cases:
  - Ack event and timeout in the same cycle: ack wins; timeout_o stays 0.
  - Ack event while IDLE: ignored.
  - A host write to a client id during HOLD is delivered normally; HOLD is not affected.
  - A new request is never granted in the same cycle that HOLD exits; IDLE always lasts at least 1 cycle, so the host sees ACK_ID between bytes.
  - A client that drops tx_req_i before being granted loses nothing; tx_ack_o is only pulsed when a grant happens.
  - Reset asserted mid-HOLD: the held byte is lost; no tx_ack_o or timeout_o is produced.
  - reg_update_i pulses shorter than 2 clk_i periods may be missed; the jtck-side protocol guarantees longer pulses.

Decomposition:
- Package jtag_resp_pkg holds: FSM state encoding (IDLE=1'b0, HOLD=1'b1), ACK_ID default, and the byte width constant (8).
- One natural sub-module: rr_arbiter (NUM_REQ-wide request vector plus pointer in; one-hot grant and encoded id out; purely combinational).
- The synchronizer and edge detector stay inline.

Test Plan:
- Reset, then tx_req_i=3'b001 with byte 8'hA5 → 1 cycle later reg_d_o=A5, reg_addr_d_o=0, tx_ack_o=001 for 1 cycle, busy_o=1.
- tx_req_i=3'b111 held continuously, host acks each byte → grant order 0,1,2,0,…; reg_addr_d_o shows 7 for at least 1 cycle between bytes.
- Host write (reg_addr_q_i=2, reg_q_i=8'h3C) with a 4-cycle reg_update_i pulse → rx_valid_o=100 exactly once, rx_data_o=3C, 3 cycles after the rise is first captured.
- Host writes with reg_addr_q_i=5 (NUM_REQ=3), and ack while IDLE → no output change.
- TO_W=4 with the host silent in HOLD → timeout_o pulses on the 15th HOLD cycle, reg_addr_d_o=7; ack arriving on exactly that cycle → no timeout_o, normal return to IDLE.
- rst_i asserted mid-HOLD → all outputs return to reset values asynchronously; after release the RR pointer is 0.

Source files
------------

// File: rtl/jtag_resp_pkg.sv
// Shared types and constants for the JTAG response arbiter slice.
package jtag_resp_pkg;

    localparam int         BYTE_W         = 8;
    localparam logic [2:0] ACK_ID_DEFAULT = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting id at or above the
// pointer wins, otherwise the lowest requesting id below it (wrap-around).
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] grant,
    output logic [2:0]   id,
    output logic         valid
);

    // NOTE: every output gets a default before the search loops, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        id    = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (3'(i) >= ptr)) begin
                valid    = 1'b1;
                grant[i] = 1'b1;
                id       = 3'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (3'(i) < ptr)) begin
                valid    = 1'b1;
                grant[i] = 1'b1;
                id       = 3'(i);
            end
        end
    end

endmodule

// File: rtl/jtag_resp_arbiter.sv
// Shares the JTAG response register among on-tile clients (round-robin, held
// until host ack or timeout) and routes host-written bytes to the addressed client.
module jtag_resp_arbiter
    import jtag_resp_pkg::*;
#(
    parameter int         NUM_REQ = 3,
    parameter logic [2:0] ACK_ID  = ACK_ID_DEFAULT,
    parameter int         TO_W    = 16,
    parameter int         TO_EN   = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        reg_update_i,
    input  logic [BYTE_W-1:0]           reg_q_i,
    input  logic [2:0]                  reg_addr_q_i,
    output logic [BYTE_W-1:0]           reg_d_o,
    output logic [2:0]                  reg_addr_d_o,
    input  logic [NUM_REQ-1:0]          tx_req_i,
    input  logic [BYTE_W*NUM_REQ-1:0]   tx_data_i,
    output logic [NUM_REQ-1:0]          tx_ack_o,
    output logic [NUM_REQ-1:0]          rx_valid_o,
    output logic [BYTE_W-1:0]           rx_data_o,
    output logic                        timeout_o,
    output logic                        busy_o
);

    // Counter value during the (2^TO_W-1)th HOLD cycle; it reads 0 in the first.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    logic                sync1, sync2, sync3;
    logic                upd_pulse;
    logic                ack_evt;
    logic [NUM_REQ-1:0]  rx_hit;

    state_t              state, state_nxt;
    logic [2:0]          rr_ptr, rr_ptr_nxt;
    logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
    logic                grant_en, hold_exit, to_fire;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [2:0]          arb_id;
    logic                arb_valid;
    logic [BYTE_W-1:0]   tx_byte;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= reg_update_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign upd_pulse = sync2 & ~sync3;

    always_comb begin
        rx_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rx_hit[i] = (reg_addr_q_i == 3'(i));
        end
    end

    // Host byte and address are stable by the time the synchronized strobe arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_valid_o <= '0;
            rx_data_o  <= '0;
            ack_evt    <= 1'b0;
        end else begin
            rx_valid_o <= '0;
            ack_evt    <= 1'b0;
            if (upd_pulse) begin
                rx_valid_o <= rx_hit;
                ack_evt    <= (reg_addr_q_i == ACK_ID);
                if (|rx_hit) begin
                    rx_data_o <= reg_q_i;
                end
            end
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req   (tx_req_i),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .id    (arb_id),
        .valid (arb_valid)
    );

    always_comb begin
        tx_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                tx_byte = tx_byte | tx_data_i[BYTE_W*i +: BYTE_W];
            end
        end
    end

    assign rr_ptr_nxt = (arb_id == 3'(NUM_REQ - 1)) ? 3'd0 : arb_id + 3'd1;

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        grant_en   = 1'b0;
        hold_exit  = 1'b0;
        to_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt  = HOLD;
                    grant_en   = 1'b1;
                    to_cnt_nxt = '0;
                end
            end
            HOLD: begin
                // An ack landing on the timeout cycle takes priority.
                if (ack_evt) begin
                    state_nxt = IDLE;
                    hold_exit = 1'b1;
                end else if ((TO_EN != 0) && (to_cnt == TO_LAST)) begin
                    state_nxt = IDLE;
                    hold_exit = 1'b1;
                    to_fire   = 1'b1;
                end else if (to_cnt != TO_MAX) begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            to_cnt       <= '0;
            reg_d_o      <= '0;
            reg_addr_d_o <= ACK_ID;
            tx_ack_o     <= '0;
            timeout_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            to_cnt    <= to_cnt_nxt;
            tx_ack_o  <= '0;
            timeout_o <= to_fire;
            if (grant_en) begin
                reg_d_o      <= tx_byte;
                reg_addr_d_o <= arb_id;
                tx_ack_o     <= arb_grant;
                rr_ptr       <= rr_ptr_nxt;
            end
            if (hold_exit) begin
                reg_addr_d_o <= ACK_ID;
            end
        end
    end

    assign busy_o = (state == HOLD);

endmodule

// File: tb/tb_jtag_resp_arbiter.sv
// Directed bench for jtag_resp_arbiter: a cycle table for grant/ack sequencing
// plus hand-written sequences for rx delivery, ignored writes, timeout and reset.
module tb_jtag_resp_arbiter;

    localparam int NUM_REQ = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  reg_update;
    logic [7:0]            reg_q;
    logic [2:0]            reg_addr_q;
    logic [7:0]            reg_d;
    logic [2:0]            reg_addr_d;
    logic [NUM_REQ-1:0]    tx_req;
    logic [8*NUM_REQ-1:0]  tx_data;
    logic [NUM_REQ-1:0]    tx_ack;
    logic [NUM_REQ-1:0]    rx_valid;
    logic [7:0]            rx_data;
    logic                  timeout;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    logic [NUM_REQ-1:0] rx_seen;
    logic               to_seen;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] data;
        logic        upd;
        logic [7:0]  exp_d;
        logic [2:0]  exp_a;
        logic [2:0]  exp_ack;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    jtag_resp_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ACK_ID  (3'd7),
        .TO_W    (4),
        .TO_EN   (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reg_update_i (reg_update),
        .reg_q_i      (reg_q),
        .reg_addr_q_i (reg_addr_q),
        .reg_d_o      (reg_d),
        .reg_addr_d_o (reg_addr_d),
        .tx_req_i     (tx_req),
        .tx_data_i    (tx_data),
        .tx_ack_o     (tx_ack),
        .rx_valid_o   (rx_valid),
        .rx_data_o    (rx_data),
        .timeout_o    (timeout),
        .busy_o       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full host write: strobe high for 3 clocks, then low for one; the write
    // takes effect on the last of those edges. Records stray rx/timeout pulses.
    task automatic host_write(input logic [7:0] q, input logic [2:0] a);
        rx_seen    = '0;
        to_seen    = 1'b0;
        reg_q      = q;
        reg_addr_q = a;
        reg_update = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) reg_update = 1'b0;
            step();
            rx_seen = rx_seen | rx_valid;
            to_seen = to_seen | timeout;
        end
    endtask

    function automatic vec_t mk(input logic [2:0] req, input logic [23:0] data, input logic upd,
                                input logic [7:0] ed, input logic [2:0] ea,
                                input logic [2:0] eack, input logic eb);
        vec_t v;
        v.req = req; v.data = data; v.upd = upd;
        v.exp_d = ed; v.exp_a = ea; v.exp_ack = eack; v.exp_busy = eb;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        logic done;
        logic early_to;

        // Grant 0, ack; then all three requesting: grants 1, 2, 0 with an
        // ACK_ID gap after every ack even though requests never drop.
        vecs[0]  = mk(3'b001, 24'h0000A5, 1'b0, 8'hA5, 3'd0, 3'b001, 1'b1);
        vecs[1]  = mk(3'b000, 24'h0000A5, 1'b1, 8'hA5, 3'd0, 3'b000, 1'b1);
        vecs[2]  = mk(3'b000, 24'h0000A5, 1'b1, 8'hA5, 3'd0, 3'b000, 1'b1);
        vecs[3]  = mk(3'b000, 24'h0000A5, 1'b1, 8'hA5, 3'd0, 3'b000, 1'b1);
        vecs[4]  = mk(3'b000, 24'h0000A5, 1'b0, 8'hA5, 3'd7, 3'b000, 1'b0);
        vecs[5]  = mk(3'b111, 24'h332211, 1'b0, 8'h22, 3'd1, 3'b010, 1'b1);
        vecs[6]  = mk(3'b111, 24'h665544, 1'b1, 8'h22, 3'd1, 3'b000, 1'b1);
        vecs[7]  = mk(3'b111, 24'h665544, 1'b1, 8'h22, 3'd1, 3'b000, 1'b1);
        vecs[8]  = mk(3'b111, 24'h665544, 1'b1, 8'h22, 3'd1, 3'b000, 1'b1);
        vecs[9]  = mk(3'b111, 24'h665544, 1'b0, 8'h22, 3'd7, 3'b000, 1'b0);
        vecs[10] = mk(3'b111, 24'h665544, 1'b0, 8'h66, 3'd2, 3'b100, 1'b1);
        vecs[11] = mk(3'b111, 24'h665544, 1'b1, 8'h66, 3'd2, 3'b000, 1'b1);
        vecs[12] = mk(3'b111, 24'h665544, 1'b1, 8'h66, 3'd2, 3'b000, 1'b1);
        vecs[13] = mk(3'b111, 24'h665544, 1'b1, 8'h66, 3'd2, 3'b000, 1'b1);
        vecs[14] = mk(3'b111, 24'h665544, 1'b0, 8'h66, 3'd7, 3'b000, 1'b0);
        vecs[15] = mk(3'b111, 24'h665544, 1'b0, 8'h44, 3'd0, 3'b001, 1'b1);

        rst        = 1'b0;
        reg_update = 1'b0;
        reg_q      = 8'h00;
        reg_addr_q = 3'd7;
        tx_req     = '0;
        tx_data    = '0;

        // Reset applied with no clock edge yet.
        #2 rst = 1'b1;
        #1;
        check("reset reg_d", 32'(reg_d), 32'h00);
        check("reset reg_addr_d", 32'(reg_addr_d), 32'd7);
        check("reset busy", 32'(busy), 32'd0);
        check("reset tx_ack", 32'(tx_ack), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset timeout", 32'(timeout), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            tx_req     = vecs[i].req;
            tx_data    = vecs[i].data;
            reg_update = vecs[i].upd;
            step();
            check($sformatf("vec%0d reg_d", i), 32'(reg_d), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d reg_addr_d", i), 32'(reg_addr_d), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d tx_ack", i), 32'(tx_ack), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'd0);
        end

        // Host write to client 2 during HOLD (id 0): 4-cycle strobe, single
        // pulse on the third edge after the rise; HOLD is undisturbed.
        tx_req     = '0;
        reg_q      = 8'h3C;
        reg_addr_q = 3'd2;
        reg_update = 1'b1;
        pulses     = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) reg_update = 1'b0;
            step();
            if (rx_valid != '0) pulses++;
            check($sformatf("rx cyc%0d rx_valid", i), 32'(rx_valid), (i == 3) ? 32'b100 : 32'b000);
        end
        check("rx pulse count", 32'(pulses), 32'd1);
        check("rx data", 32'(rx_data), 32'h3C);
        check("rx hold busy", 32'(busy), 32'd1);
        check("rx hold addr", 32'(reg_addr_d), 32'd0);

        host_write(8'h00, 3'd7);
        check("ack busy", 32'(busy), 32'd0);
        check("ack addr", 32'(reg_addr_d), 32'd7);
        check("ack reg_d kept", 32'(reg_d), 32'h44);
        check("ack no timeout", 32'(to_seen), 32'd0);
        step();
        step();

        // Unmapped address, then ack while IDLE: nothing changes.
        host_write(8'h55, 3'd5);
        check("addr5 rx_valid", 32'(rx_seen), 32'd0);
        check("addr5 rx_data", 32'(rx_data), 32'h3C);
        check("addr5 busy", 32'(busy), 32'd0);
        check("addr5 addr", 32'(reg_addr_d), 32'd7);
        step();
        step();
        host_write(8'h00, 3'd7);
        check("idle ack busy", 32'(busy), 32'd0);
        check("idle ack addr", 32'(reg_addr_d), 32'd7);
        check("idle ack reg_d", 32'(reg_d), 32'h44);
        check("idle ack rx_valid", 32'(rx_seen), 32'd0);
        step();
        step();

        // Timeout: pointer is 1, only client 0 requests (wrap-around grant).
        tx_data = 24'h00005A;
        tx_req  = 3'b001;
        step();
        check("to grant addr", 32'(reg_addr_d), 32'd0);
        check("to grant reg_d", 32'(reg_d), 32'h5A);
        check("to grant tx_ack", 32'(tx_ack), 32'b001);
        tx_req   = '0;
        tx_data  = 24'h000077;
        n        = busy ? 1 : 0;
        done     = 1'b0;
        early_to = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (busy) begin
                n++;
                if (timeout) early_to = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        check("to exit reached", 32'(done), 32'd1);
        check("to hold cycles", 32'(n), 32'd15);
        check("to early pulse", 32'(early_to), 32'd0);
        check("to pulse", 32'(timeout), 32'd1);
        check("to addr", 32'(reg_addr_d), 32'd7);
        check("to reg_d frozen", 32'(reg_d), 32'h5A);
        step();
        check("to pulse width", 32'(timeout), 32'd0);
        step();

        // Ack takes effect on exactly the timeout cycle: ack wins.
        tx_req = 3'b001;
        step();
        check("race grant busy", 32'(busy), 32'd1);
        tx_req = '0;
        repeat (11) step();
        host_write(8'h00, 3'd7);
        check("race busy", 32'(busy), 32'd0);
        check("race addr", 32'(reg_addr_d), 32'd7);
        check("race no timeout", 32'(to_seen), 32'd0);
        step();
        check("race timeout after", 32'(timeout), 32'd0);
        step();

        // Reset mid-HOLD with the pointer at 2; afterwards the pointer is 0.
        tx_data = 24'h00BB00;
        tx_req  = 3'b010;
        step();
        check("pre-rst grant addr", 32'(reg_addr_d), 32'd1);
        tx_req = '0;
        step();
        step();
        #3 rst = 1'b1;
        #1;
        check("mid rst reg_d", 32'(reg_d), 32'h00);
        check("mid rst addr", 32'(reg_addr_d), 32'd7);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst tx_ack", 32'(tx_ack), 32'd0);
        check("mid rst rx_data", 32'(rx_data), 32'h00);
        check("mid rst timeout", 32'(timeout), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        tx_data = 24'hCC00DD;
        tx_req  = 3'b101;
        step();
        check("post rst grant addr", 32'(reg_addr_d), 32'd0);
        check("post rst reg_d", 32'(reg_d), 32'hDD);
        check("post rst tx_ack", 32'(tx_ack), 32'b001);
        tx_req = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
